// File: rtl/add2_pkg.sv
// Shared widths and packed types for the registered 2-bit adder.
// The pattern layout matches the ISCAS pin order: N1 is the LSB, N5 the MSB.
package add2_pkg;

  localparam int ADD2_W  = 2;
  localparam int ADD2_RW = 3;

  // Input pattern {N5, N4, N3, N2, N1} = {cin, B[1:0], A[1:0]}
  typedef struct packed {
    logic              cin;
    logic [ADD2_W-1:0] b;
    logic [ADD2_W-1:0] a;
  } add2_pat_t;

  // Result {N52, N51, N50} = {cout, sum[1:0]}
  typedef struct packed {
    logic              cout;
    logic [ADD2_W-1:0] sum;
  } add2_res_t;

endpackage

// File: rtl/add2_fa.sv
// One gate-level full adder cell.
// The XOR output is a named net so it remains a fault-injection site.
module add2_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign s     = w_axb ^ ci;
  assign co    = (a & b) | (ci & w_axb);

endmodule

// File: rtl/add2_reg.sv
// Registered 2-bit ripple-carry adder with carry-in/out and ISCAS pin names.
// The combinational core feeds a single result register; latency is one cycle.
module add2_reg
  import add2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic N5,
  output logic out_valid,
  output logic N50,
  output logic N51,
  output logic N52
);

  // Handshake: valid-only, no ready. A pattern is accepted on every rising
  // clk with in_valid=1; out_valid is the one-cycle-delayed in_valid, and the
  // result register only loads on accepted patterns, so it holds otherwise.

  add2_pat_t w_pat;
  add2_res_t w_res;
  logic      w_c1;
  logic      w_s0;
  logic      w_s1;
  logic      w_c2;

  add2_res_t r_res;
  logic      r_out_valid;

  assign w_pat.a   = {N2, N1};
  assign w_pat.b   = {N4, N3};
  assign w_pat.cin = N5;

  add2_fa u_fa0 (
    .a  (w_pat.a[0]),
    .b  (w_pat.b[0]),
    .ci (w_pat.cin),
    .s  (w_s0),
    .co (w_c1)
  );

  add2_fa u_fa1 (
    .a  (w_pat.a[1]),
    .b  (w_pat.b[1]),
    .ci (w_c1),
    .s  (w_s1),
    .co (w_c2)
  );

  assign w_res.sum  = {w_s1, w_s0};
  assign w_res.cout = w_c2;

  // Inputs are ignored entirely while in_valid=0, so X/Z there cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_res <= w_res;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign N50       = r_res.sum[0];
  assign N51       = r_res.sum[1];
  assign N52       = r_res.cout;

endmodule

// File: tb/tb_add2_reg.sv
// Directed bench for add2_reg: reset, directed sums, exhaustive sweep,
// hold across gaps and asynchronous reset in the middle of a stream.
module tb_add2_reg;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic N1, N2, N3, N4, N5;
  logic out_valid;
  logic N50, N51, N52;

  logic [2:0] exp_q[$];
  logic [2:0] hold_val;
  int         n_vec;
  int         n_err;

  add2_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .N1        (N1),
    .N2        (N2),
    .N3        (N3),
    .N4        (N4),
    .N5        (N5),
    .out_valid (out_valid),
    .N50       (N50),
    .N51       (N51),
    .N52       (N52)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_sum(input logic [4:0] p);
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
    a = {1'b0, p[1:0]};
    b = {1'b0, p[3:2]};
    c = {2'b00, p[4]};
    return a + b + c;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] p);
    in_valid = v;
    {N5, N4, N3, N2, N1} = p;
  endtask

  // One clock of stimulus: drive at negedge, check 1 ns after the next posedge.
  task automatic step(input string tag, input logic v, input logic [4:0] p);
    logic [2:0] e;
    @(negedge clk);
    drive(v, p);
    if (v) exp_q.push_back(ref_sum(p));
    @(posedge clk);
    #1;
    chk({tag, "_ov"}, {2'b00, out_valid}, {2'b00, v});
    if (v) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 3'b001, 3'b000);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_sum"}, {N52, N51, N50}, e);
        hold_val = e;
      end
    end else begin
      chk({tag, "_hold"}, {N52, N51, N50}, hold_val);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    hold_val = 3'b000;
    rst_n    = 1'b0;
    drive(1'b1, 5'($urandom_range(0, 31)));

    // Reset held with active random stimulus
    #1;
    chk("rst_t0_res", {N52, N51, N50}, 3'b000);
    chk("rst_t0_ov", {2'b00, out_valid}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 5'($urandom_range(0, 31)));
      @(posedge clk);
      #1;
      chk("rst_hold_res", {N52, N51, N50}, 3'b000);
      chk("rst_hold_ov", {2'b00, out_valid}, 3'b000);
    end
    @(negedge clk);
    drive(1'b0, 5'b00000);
    rst_n = 1'b1;
    step("post_rst_idle", 1'b0, 5'b10101);

    // Directed sums
    step("a1_b2", 1'b1, 5'b0_10_01);
    step("max", 1'b1, 5'b1_11_11);
    step("a2_b2", 1'b1, 5'b0_10_10);

    // Exhaustive back-to-back sweep
    for (int p = 0; p < 32; p++) begin
      step("exh", 1'b1, 5'(p));
    end

    // Hold across a gap with toggling and unknown inputs
    step("gap_load", 1'b1, 5'b11111);
    step("gap0", 1'b0, 5'($urandom_range(0, 31)));
    @(negedge clk);
    in_valid = 1'b0;
    {N5, N4, N3, N2, N1} = 5'bxxxxx;
    @(posedge clk);
    #1;
    chk("gap_x_ov", {2'b00, out_valid}, 3'b000);
    chk("gap_x_hold", {N52, N51, N50}, hold_val);
    step("gap2", 1'b0, 5'($urandom_range(0, 31)));
    step("gap_zero", 1'b1, 5'b00000);

    // Asynchronous reset between edges after a captured result
    step("mid_load", 1'b1, 5'b01011);
    chk("mid_load_val", {N52, N51, N50}, 3'b101);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", {N52, N51, N50}, 3'b000);
    chk("mid_rst_ov", {2'b00, out_valid}, 3'b000);
    hold_val = 3'b000;
    exp_q.delete();
    @(negedge clk);
    drive(1'b1, 5'b11111);
    @(posedge clk);
    #1;
    chk("mid_rst_edge_res", {N52, N51, N50}, 3'b000);
    chk("mid_rst_edge_ov", {2'b00, out_valid}, 3'b000);
    @(negedge clk);
    drive(1'b0, 5'b00000);
    rst_n = 1'b1;
    step("after_rst", 1'b1, 5'b1_01_10);
    step("after_rst2", 1'b1, 5'b0_11_01);
    step("final_idle", 1'b0, 5'b00000);

    if (exp_q.size() != 0) chk("sb_leftover", 3'(exp_q.size()), 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
